// File: rtl/seg_scan_reader_pkg.sv
//==============================================================================
// seg_scan_reader_pkg : shared fetch-FSM state type and 7-segment font table
// Revision: 1.0
//==============================================================================
`default_nettype none

package seg_scan_reader_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; listed from F down to 0 so HEX_SEG[n] is digit n
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

`default_nettype wire

// File: rtl/seg_scan_reader_hex7seg.sv
//==============================================================================
// hex7seg : combinational 4-bit nibble to active-low 7-segment pattern
// Revision: 1.0
//==============================================================================
`default_nettype none

module hex7seg
    import seg_scan_reader_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    assign pattern = HEX_SEG[nibble];

endmodule

`default_nettype wire

// File: rtl/seg_scan_reader.sv
//==============================================================================
// seg_scan_reader : fetches one data-memory word per frame, scans it as 8 hex
// digits. Optional macro SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits.
// Revision: 1.0
//==============================================================================
`default_nettype none

module seg_scan_reader
    import seg_scan_reader_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int RD_AW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RD_AW-1:0] addr,
    output logic             rd_req,
    output logic [RD_AW-1:0] rd_addr,
    input  logic             rd_valid,
    input  logic [31:0]      rd_data,
    output logic [7:0]       anode,
    output logic [7:0]       segment
);

    logic [DIV_W-1:0] divider;
    logic [2:0]       digit;
    logic [31:0]      disp_word;
    logic             first_fetch;
    fetch_state_t     state;
    logic             div_wrap;
    logic             frame_tick;
    logic [3:0]       nibble;
    logic [7:0]       hex_pattern;
    logic             blank;

    assign div_wrap   = &divider;
    assign frame_tick = div_wrap && (digit == 3'd7);
    assign nibble     = disp_word[{digit, 2'b00} +: 4];

`ifdef SEG_BLANK_LEADING_ZERO_EN
    // Digit 0 is always shown so a zero word still reads "0"
    assign blank = (digit != 3'd0) && ((disp_word >> {digit, 2'b00}) == 32'd0);
`else
    assign blank = 1'b0;
`endif

    hex7seg u_hex7seg (
        .nibble  (nibble),
        .pattern (hex_pattern)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divider <= '0;
            digit   <= 3'd0;
            anode   <= 8'hFF;
            segment <= SEG_BLANK;
        end else begin
            divider <= divider + DIV_W'(1);
            if (div_wrap) begin
                digit <= digit + 3'd1;
            end
            anode   <= ~(8'b1 << digit);
            segment <= blank ? SEG_BLANK : hex_pattern;
        end
    end

    // Frame ticks arriving while a read is outstanding are dropped, never queued
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            first_fetch <= 1'b1;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            disp_word   <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (first_fetch || frame_tick) begin
                        state       <= ST_REQ;
                        first_fetch <= 1'b0;
                        rd_req      <= 1'b1;
                        rd_addr     <= addr;
                    end
                end
                ST_REQ: begin
                    if (rd_valid) begin
                        state     <= ST_IDLE;
                        rd_req    <= 1'b0;
                        disp_word <= rd_data;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    rd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_reader.sv
//==============================================================================
// tb_seg_scan_reader : randomized scoreboard bench against a cycle-count model
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seg_scan_reader;

    localparam int DIV_W = 2;
    localparam int RD_AW = 8;
    localparam int FRAME = 8 * (1 << DIV_W);

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [7:0]  addr     = 8'h00;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data  = 32'd0;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic [7:0]  anode;
    logic [7:0]  segment;

    seg_scan_reader #(.DIV_W(DIV_W), .RD_AW(RD_AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .anode    (anode),
        .segment  (segment)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] anode;
        logic [7:0] segment;
        logic       rd_req;
    } disp_exp_t;

    disp_exp_t  disp_q[$];
    logic [7:0] req_q[$];
    int         errors = 0;
    int         checks = 0;

    int          m_edges = 0;
    bit          m_busy  = 1'b0;
    logic [31:0] m_word  = 32'd0;

    function automatic logic [7:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;
            4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;
            4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;
            4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;
            4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic void check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: m_edges counts clock edges since reset release; digit and frame
    // timing follow directly from that count.
    always @(posedge clk) begin
        disp_exp_t   e;
        int          d;
        logic [31:0] upper;
        bit          start;
        if (!rst_n) begin
            m_edges = 0;
            m_busy  = 1'b0;
            m_word  = 32'd0;
            e       = '{8'hFF, 8'hFF, 1'b0};
        end else begin
            d         = (m_edges >> DIV_W) % 8;
            e.anode   = ~(8'h01 << d);
            upper     = m_word >> (4 * d);
            e.segment = hex_font(upper[3:0]);
`ifdef SEG_BLANK_LEADING_ZERO_EN
            if (d != 0 && upper == 32'd0) e.segment = 8'hFF;
`endif
            start = !m_busy && (m_edges == 0 || (m_edges % FRAME) == FRAME - 1);
            if (m_busy && rd_valid) begin
                m_word = rd_data;
                m_busy = 1'b0;
            end
            if (start) begin
                m_busy = 1'b1;
                req_q.push_back(addr);
            end
            e.rd_req = m_busy;
            m_edges++;
        end
        disp_q.push_back(e);
    end

    logic       prev_req = 1'b0;
    logic [7:0] held_addr = 8'h00;

    always @(negedge clk) begin
        disp_exp_t e;
        if (disp_q.size() > 0) begin
            e = disp_q.pop_front();
            check8("anode", anode, e.anode);
            check8("segment", segment, e.segment);
            check8("rd_req", {7'd0, rd_req}, {7'd0, e.rd_req});
        end
        if (rd_req && !prev_req) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_addr: unexpected request rd_addr=%h expected no request", rd_addr);
            end else begin
                held_addr = req_q.pop_front();
                check8("rd_addr", rd_addr, held_addr);
            end
        end else if (rd_req) begin
            check8("rd_addr_hold", rd_addr, held_addr);
        end
        prev_req = rd_req;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!rd_req && n < 400) begin
            step();
            n++;
        end
        if (!rd_req) begin
            checks++;
            errors++;
            $display("FAIL wait_req: timeout rd_req=%b expected 1", rd_req);
        end
    endtask

    task automatic respond(input int delay, input logic [31:0] data);
        wait_req();
        repeat (delay) step();
        rd_valid = 1'b1;
        rd_data  = data;
        step();
        rd_valid = 1'b0;
        rd_data  = $urandom;
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = 8'h10;
        repeat (3) step();
        rst_n = 1'b1;
        respond(1, 32'h1234ABCD);
        repeat (FRAME + 4) step();

        // Withhold the response for three frames, moving addr mid-request
        wait_req();
        step();
        addr = 8'h20;
        repeat (3 * FRAME) step();
        respond(0, 32'h0BADF00D);

        // Stray strobe while idle must not touch the display
        repeat (3) step();
        if (!rd_req) begin
            rd_valid = 1'b1;
            rd_data  = 32'hDEADBEEF;
            step();
            rd_valid = 1'b0;
        end
        repeat (FRAME) step();

        respond(2, 32'h000000A5);
        repeat (FRAME + 2) step();

        for (int i = 0; i < 12; i++) begin
            addr = 8'($urandom);
            respond($urandom_range(0, 40), (i % 3 == 0) ? ($urandom & 32'h0000FFFF) : $urandom);
            repeat ($urandom_range(0, FRAME)) step();
        end

        // Reset during an outstanding request, with a strobe in the same cycle
        wait_req();
        rst_n    = 1'b0;
        rd_valid = 1'b1;
        rd_data  = 32'hFFFFFFFF;
        step();
        rd_valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (FRAME + 4) step();

        respond(3, 32'hCAFE0012);
        repeat (FRAME + 4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
